// File: rtl/aes_rf_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : aes_rf_sequencer
// Description : Borrows the shared 2R/1W register-file ports for one AES
//               operation. Gathers a 128-bit state from four consecutive GPRs
//               (two per cycle), presents it to the AES round unit, then
//               writes the 128-bit result back to four consecutive GPRs
//               (one per cycle). While idle, the core drives the ports
//               directly. In every other state, the core is stalled.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  operation request (honoured only while idle)
//   src_base, dst_base     first source / destination GPR, sampled with start
//   core_rs1/rs2/rd/we/wd  core-side register-file requests
//   rf_rs1/rs2/rd/we/wd    register-file port drive
//   rf_rd1, rf_rd2         register-file read data (combinational)
//   op_valid, op_state     state handed to the AES unit (word k at [32k+:32])
//   op_done, op_result     AES unit result handshake
//   core_stall, busy       high whenever not idle
//   done                   one-cycle pulse after the last write-back
//   err                    one-cycle pulse after a timeout abort
// ============================================================================
module aes_rf_sequencer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [4:0]   src_base,
    input  logic [4:0]   dst_base,
    input  logic [4:0]   core_rs1,
    input  logic [4:0]   core_rs2,
    input  logic [4:0]   core_rd,
    input  logic         core_we,
    input  logic [31:0]  core_wd,
    output logic [4:0]   rf_rs1,
    output logic [4:0]   rf_rs2,
    output logic [4:0]   rf_rd,
    output logic         rf_we,
    output logic [31:0]  rf_wd,
    input  logic [31:0]  rf_rd1,
    input  logic [31:0]  rf_rd2,
    output logic         op_valid,
    output logic [127:0] op_state,
    input  logic         op_done,
    input  logic [127:0] op_result,
    output logic         core_stall,
    output logic         busy,
    output logic         done,
    output logic         err
);

    // The write states occupy 4..7, so the low two bits are the word index.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD0  = 3'd1;
    localparam logic [2:0] S_RD1  = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_WR0  = 3'd4;
    localparam logic [2:0] S_WR1  = 3'd5;
    localparam logic [2:0] S_WR2  = 3'd6;
    localparam logic [2:0] S_WR3  = 3'd7;

    // The counter holds 0..TIMEOUT-1. The abort fires in the EXEC cycle
    // where the counter reaches TIMEOUT-1 with no op_done.
    localparam int unsigned    c_TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TW-1:0] c_TLIMIT = c_TW'(TIMEOUT - 1);
    localparam bit             c_TO_EN  = (TIMEOUT != 0);

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [4:0]      r_src;
    logic [4:0]      r_dst;
    logic [127:0]    r_op_state;
    logic [127:0]    r_result;
    logic [c_TW-1:0] r_tcnt;
    logic            r_op_valid;
    logic            r_done;
    logic            r_err;
    logic            w_timeout;

    // Next-state logic. op_done is tested before the timeout, so op_done
    // takes priority when both occur in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_RD0;
            S_RD0:  w_state_nxt = S_RD1;
            S_RD1:  w_state_nxt = S_EXEC;
            S_EXEC: begin
                if (op_done) begin
                    w_state_nxt = S_WR0;
                end else if (c_TO_EN && (r_tcnt == c_TLIMIT)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WR0:  w_state_nxt = S_WR1;
            S_WR1:  w_state_nxt = S_WR2;
            S_WR2:  w_state_nxt = S_WR3;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Port steering. While idle, the core drives the ports. Otherwise the
    // core write enable is masked, and the sequencer takes the addresses it
    // needs. Address adds wrap modulo 32.
    always_comb begin
        rf_rs1 = core_rs1;
        rf_rs2 = core_rs2;
        rf_rd  = core_rd;
        rf_we  = core_we;
        rf_wd  = core_wd;
        if (r_state != S_IDLE) begin
            rf_we = 1'b0;
        end
        case (r_state)
            S_RD0: begin
                rf_rs1 = r_src;
                rf_rs2 = r_src + 5'd1;
            end
            S_RD1: begin
                rf_rs1 = r_src + 5'd2;
                rf_rs2 = r_src + 5'd3;
            end
            S_WR0, S_WR1, S_WR2, S_WR3: begin
                rf_we = 1'b1;
                rf_rd = r_dst + {3'b000, r_state[1:0]};
                rf_wd = r_result[{r_state[1:0], 5'b00000} +: 32];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_src      <= 5'd0;
            r_dst      <= 5'd0;
            r_op_state <= 128'd0;
            r_result   <= 128'd0;
            r_tcnt     <= '0;
            r_op_valid <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_op_valid <= (w_state_nxt == S_EXEC);
            r_done     <= (r_state == S_WR3);
            r_err      <= w_timeout;

            if ((r_state == S_IDLE) && start) begin
                r_src <= src_base;
                r_dst <= dst_base;
            end

            if (r_state == S_RD0) begin
                r_op_state[31:0]  <= rf_rd1;
                r_op_state[63:32] <= rf_rd2;
            end
            if (r_state == S_RD1) begin
                r_op_state[95:64]  <= rf_rd1;
                r_op_state[127:96] <= rf_rd2;
            end

            // Holding the counter at zero outside EXEC gives a clean count
            // on every EXEC entry.
            if (r_state == S_EXEC) begin
                r_tcnt <= r_tcnt + 1'b1;
            end else begin
                r_tcnt <= '0;
            end

            if ((r_state == S_EXEC) && op_done) begin
                r_result <= op_result;
            end
        end
    end

    assign core_stall = (r_state != S_IDLE);
    assign busy       = core_stall;
    assign op_valid   = r_op_valid;
    assign op_state   = r_op_state;
    assign done       = r_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_rf_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_rf_sequencer
// Description : Self-checking bench for aes_rf_sequencer. It uses a
//               behavioural register file, a behavioural AES responder with
//               programmable latency, and a scoreboard of expected events
//               (register writes, AES state hand-off, done and err pulses).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_rf_sequencer;

    localparam int K_WR   = 0;
    localparam int K_OPS  = 1;
    localparam int K_DONE = 2;
    localparam int K_ERR  = 3;

    typedef struct {
        int           kind;
        logic [31:0]  a;
        logic [127:0] d;
        int           cyc;
    } ev_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [4:0]   src_base, dst_base;
    logic [4:0]   core_rs1, core_rs2, core_rd;
    logic         core_we;
    logic [31:0]  core_wd;
    logic [4:0]   rf_rs1, rf_rs2, rf_rd;
    logic         rf_we;
    logic [31:0]  rf_wd, rf_rd1, rf_rd2;
    logic         op_valid;
    logic [127:0] op_state;
    logic         op_done;
    logic [127:0] op_result;
    logic         core_stall, busy, done, err;

    int           n_checks;
    int           n_fail;
    int           cyc;
    ev_t          q[$];
    logic [31:0]  gold [0:31];
    logic [31:0]  mem  [0:31];

    // AES responder controls
    logic         aes_en;
    int           aes_delay;
    logic         aes_mode;
    logic [127:0] aes_fixed;

    aes_rf_sequencer #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src_base(src_base), .dst_base(dst_base),
        .core_rs1(core_rs1), .core_rs2(core_rs2), .core_rd(core_rd),
        .core_we(core_we), .core_wd(core_wd),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd),
        .rf_we(rf_we), .rf_wd(rf_wd),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .op_valid(op_valid), .op_state(op_state),
        .op_done(op_done), .op_result(op_result),
        .core_stall(core_stall), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file model: x0 reads as zero, and writes to x0 are dropped.
    assign rf_rd1 = (rf_rs1 == 5'd0) ? 32'd0 : mem[rf_rs1];
    assign rf_rd2 = (rf_rs2 == 5'd0) ? 32'd0 : mem[rf_rs2];
    always @(posedge clk) begin
        if (rf_we && (rf_rd != 5'd0)) mem[rf_rd] <= rf_wd;
    end

    // AES responder: raises op_done after aes_delay cycles of op_valid.
    initial begin
        int exec_cnt;
        exec_cnt  = 0;
        op_done   = 1'b0;
        op_result = 128'd0;
        forever begin
            @(posedge clk);
            #1;
            if (op_valid) begin
                op_done   = aes_en && (exec_cnt == aes_delay);
                op_result = aes_mode ? aes_fixed : ~op_state;
                exec_cnt++;
            end else begin
                op_done  = 1'b0;
                exec_cnt = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic see(input int kind, input logic [31:0] a, input logic [127:0] d);
        ev_t e;
        if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event kind=%0d addr=%0d data=%h required=none (cycle %0d)",
                     kind, a, d, cyc);
        end else begin
            e = q.pop_front();
            chk("ev_kind", 128'(kind), 128'(e.kind));
            chk("ev_addr", {96'd0, a}, {96'd0, e.a});
            chk("ev_data", d, e.d);
            if (e.cyc >= 0) chk("ev_cycle", 128'(cyc), 128'(e.cyc));
        end
    endtask

    // Monitor: pops and compares whenever the DUT presents an event.
    initial begin
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (done) see(K_DONE, 32'd0, 128'd0);
                if (err)  see(K_ERR, 32'd0, 128'd0);
                if (op_valid && !prev_v) see(K_OPS, 32'd0, op_state);
                if (rf_we) see(K_WR, {27'd0, rf_rd}, {96'd0, rf_wd});
                prev_v = op_valid;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int kind, input logic [31:0] a, input logic [127:0] d, input int c);
        ev_t e;
        e.kind = kind; e.a = a; e.d = d; e.cyc = c;
        q.push_back(e);
    endtask

    // Expected state from the golden register image.
    function automatic logic [127:0] gold_state(input logic [4:0] s);
        logic [127:0] st;
        for (int k = 0; k < 4; k++) st[32*k +: 32] = gold[5'(int'(s) + k)];
        return st;
    endfunction

    task automatic push_op(input logic [4:0] s, input logic [4:0] d, input int dcyc);
        logic [127:0] st, res;
        logic [4:0]   a;
        st  = gold_state(s);
        res = aes_mode ? aes_fixed : ~st;
        push_ev(K_OPS, 32'd0, st, -1);
        for (int k = 0; k < 4; k++) begin
            a = 5'(int'(d) + k);
            push_ev(K_WR, {27'd0, a}, {96'd0, res[32*k +: 32]}, -1);
            if (a != 5'd0) gold[a] = res[32*k +: 32];
        end
        push_ev(K_DONE, 32'd0, 128'd0, dcyc);
    endtask

    task automatic core_write(input logic [4:0] a, input logic [31:0] v);
        core_rd = a; core_wd = v; core_we = 1'b1;
        push_ev(K_WR, {27'd0, a}, {96'd0, v}, -1);
        if (a != 5'd0) gold[a] = v;
        tick();
        core_we = 1'b0;
    endtask

    task automatic begin_op(input logic [4:0] s, input logic [4:0] d);
        src_base = s; dst_base = d; start = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        n_checks = 0; n_fail = 0; cyc = 0;
        for (int i = 0; i < 32; i++) gold[i] = 32'd0;
        rst_n = 1'b0; start = 1'b0; src_base = 5'd0; dst_base = 5'd0;
        core_rs1 = 5'd3; core_rs2 = 5'd4; core_rd = 5'd0;
        core_we = 1'b1; core_wd = 32'h12345678;
        aes_en = 1'b1; aes_delay = 0; aes_mode = 1'b0; aes_fixed = 128'd0;

        // Reset state: outputs quiet, with the ports passed straight through.
        tick(); tick();
        chk("rst_stall",    {127'd0, core_stall}, 128'd0);
        chk("rst_busy",     {127'd0, busy},       128'd0);
        chk("rst_op_valid", {127'd0, op_valid},   128'd0);
        chk("rst_done_err", {126'd0, done, err},  128'd0);
        chk("rst_pass_rs",  {118'd0, rf_rs1, rf_rs2}, {118'd0, 5'd3, 5'd4});
        chk("rst_pass_wr",  {90'd0, rf_we, rf_rd, rf_wd}, {90'd0, 1'b1, 5'd0, 32'h12345678});
        core_we = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Preload through the idle pass-through path.
        core_write(5'd1,  32'd0);
        core_write(5'd5,  32'h11111111);
        core_write(5'd8,  32'h00112233);
        core_write(5'd9,  32'h44556677);
        core_write(5'd10, 32'h8899AABB);
        core_write(5'd11, 32'hCCDDEEFF);
        tick();

        // T1: basic operation with a first-cycle op_done, plus a masked core write during RD1.
        c0 = cyc;
        begin_op(5'd8, 5'd16);
        push_op(5'd8, 5'd16, c0 + 8);
        chk("t1_stall_c0", {127'd0, core_stall}, 128'd0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) start = 1'b0;
            if (k == 2) begin core_rd = 5'd5; core_wd = 32'hDEADBEEF; core_we = 1'b1; end
            if (k == 3) core_we = 1'b0;
            chk("t1_stall", {126'd0, core_stall, busy}, {126'd0, {2{k <= 7}}});
        end
        tick();
        chk("t1_x16", {96'd0, mem[16]}, {96'd0, 32'hFFEEDDCC});
        chk("t1_x17", {96'd0, mem[17]}, {96'd0, 32'hBBAA9988});
        chk("t1_x18", {96'd0, mem[18]}, {96'd0, 32'h77665544});
        chk("t1_x19", {96'd0, mem[19]}, {96'd0, 32'h33221100});
        chk("t1_x5_kept", {96'd0, mem[5]}, {96'd0, 32'h11111111});
        core_write(5'd5, 32'hDEADBEEF);
        tick();
        chk("pass_x5", {96'd0, mem[5]}, {96'd0, 32'hDEADBEEF});

        // T2: address wrap around x31 -> x0.
        core_write(5'd30, 32'd1);
        core_write(5'd31, 32'd2);
        tick();
        aes_mode = 1'b1;
        aes_fixed = {32'd4, 32'd3, 32'd2, 32'd1};
        c0 = cyc;
        begin_op(5'd30, 5'd31);
        push_op(5'd30, 5'd31, c0 + 8);
        tick(); start = 1'b0;
        repeat (9) tick();
        chk("t2_x31", {96'd0, mem[31]}, {96'd0, 32'd1});
        chk("t2_x1",  {96'd0, mem[1]},  {96'd0, 32'd3});
        chk("t2_x2",  {96'd0, mem[2]},  {96'd0, 32'd4});
        aes_mode = 1'b0;

        // T3a: timeout with op_done never raised, so no write-back occurs.
        core_write(5'd20, 32'hA5A5A5A5);
        tick();
        aes_en = 1'b0;
        c0 = cyc;
        begin_op(5'd8, 5'd20);
        push_ev(K_OPS, 32'd0, gold_state(5'd8), -1);
        push_ev(K_ERR, 32'd0, 128'd0, c0 + 7);
        tick(); start = 1'b0;
        repeat (9) tick();
        chk("t3_x20_kept", {96'd0, mem[20]}, {96'd0, 32'hA5A5A5A5});
        chk("t3_idle", {127'd0, core_stall}, 128'd0);

        // T3b: op_done on the last permitted EXEC cycle wins.
        aes_en = 1'b1; aes_delay = 3;
        c0 = cyc;
        begin_op(5'd8, 5'd24);
        push_op(5'd8, 5'd24, c0 + 11);
        tick(); start = 1'b0;
        repeat (12) tick();
        chk("t3_x24", {96'd0, mem[24]}, {96'd0, 32'hFFEEDDCC});

        // T4: start ignored in EXEC and WR1. A start in the done cycle is accepted.
        aes_delay = 2;
        c0 = cyc;
        begin_op(5'd8, 5'd12);
        push_op(5'd8, 5'd12, c0 + 10);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) start = 1'b0;
            if (k == 4) begin_op(5'd16, 5'd0);
            if (k == 5) start = 1'b0;
            if (k == 7) begin_op(5'd16, 5'd0);
            if (k == 8) start = 1'b0;
            if (k == 10) begin
                aes_delay = 0;
                begin_op(5'd16, 5'd28);
                push_op(5'd16, 5'd28, cyc + 8);
            end
        end
        tick(); start = 1'b0;
        repeat (9) tick();
        chk("t4_x13", {96'd0, mem[13]}, {96'd0, 32'hBBAA9988});
        chk("t4_x28", {96'd0, mem[28]}, {96'd0, 32'h00112233});

        // T5: reset asserted during WR1 leaves only the WR0 write.
        c0 = cyc;
        begin_op(5'd8, 5'd4);
        push_ev(K_OPS, 32'd0, gold_state(5'd8), -1);
        push_ev(K_WR, 32'd4, {96'd0, ~gold[8]}, -1);
        gold[4] = ~gold[8];
        tick(); start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        core_rd = 5'd0; core_wd = 32'h0; core_we = 1'b1;
        #1;
        chk("t5_rst_idle", {126'd0, core_stall, op_valid}, 128'd0);
        chk("t5_rst_we",   {127'd0, rf_we}, {127'd0, 1'b1});
        tick();
        core_we = 1'b0;
        rst_n = 1'b1;
        repeat (10) tick();
        chk("t5_x4", {96'd0, mem[4]}, {96'd0, 32'hFFEEDDCC});
        chk("t5_x5_kept", {96'd0, mem[5]}, {96'd0, 32'hDEADBEEF});

        c0 = cyc;
        begin_op(5'd8, 5'd4);
        push_op(5'd8, 5'd4, c0 + 8);
        tick(); start = 1'b0;
        repeat (10) tick();
        chk("t5_x5_new", {96'd0, mem[5]}, {96'd0, 32'hBBAA9988});

        chk("sb_empty", 128'(q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_rf_sequencer.md
Name: aes_rf_sequencer

Overview:
- Owns the shared 2-read/1-write register-file ports for one AES operation.
- Gathers a 128-bit state from four consecutive GPRs, hands it to the AES round unit, and writes the 128-bit result back to four consecutive GPRs.
- Stalls the core pipeline while it holds the ports; in IDLE it is a transparent pass-through between core and register file.

Parameters:
TIMEOUT, 64, max EXEC cycles waiting for op_done before abort; 0 disables the timeout

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request an AES operation; sampled in IDLE only
src_base  in  5  first source GPR index; sampled with start
dst_base  in  5  first destination GPR index; sampled with start
core_rs1  in  5  core read address 1
core_rs2  in  5  core read address 2
core_rd  in  5  core write address
core_we  in  1  core write enable
core_wd  in  32  core write data
rf_rs1  out  5  to regfile rs1
rf_rs2  out  5  to regfile rs2
rf_rd  out  5  to regfile rd
rf_we  out  1  to regfile we
rf_wd  out  32  to regfile wd
rf_rd1  in  32  regfile read data 1 (combinational)
rf_rd2  in  32  regfile read data 2 (combinational)
op_valid  out  1  state presented to AES unit
op_state  out  128  AES input; word k in bits [32k+31:32k]
op_done  in  1  AES result valid
op_result  in  128  AES output, same word packing
core_stall  out  1  core must hold; high whenever state != IDLE
busy  out  1  same as core_stall
done  out  1  one-cycle pulse: writeback complete
err  out  1  one-cycle pulse: timeout abort

Behaviour:
- Reset (async, rst_n=0): state=IDLE; op_valid=0, done=0, err=0, state/result/base/timeout registers cleared. rf_* therefore mirror core_*.
- States: IDLE, RD0, RD1, EXEC, WR0, WR1, WR2, WR3.
- IDLE: rf_rs1/rs2/rd/we/wd = core_* (combinational). If start=1, latch src_base/dst_base and go to RD0. The core keeps the ports in the start cycle.
- RD0: rf_rs1=src+0, rf_rs2=src+1, rf_we=0. Capture rf_rd1->word0 and rf_rd2->word1 at the clock edge. Go to RD1.
- RD1: addresses src+2 and src+3. Capture word2 and word3. Go to EXEC.
- EXEC: op_valid=1 (registered, held), op_state=captured words, rf_we=0.
  - On op_done=1: capture op_result, go to WR0. op_done may arrive in the first EXEC cycle.
  - op_done outside EXEC is ignored.
- Timeout: counter clears on entry to EXEC and counts EXEC cycles. If TIMEOUT != 0 and TIMEOUT cycles pass without op_done, go to IDLE with err pulse the next cycle and no writeback. If op_done and the timeout expire in the same cycle, op_done wins.
- WRk (k=0..3): rf_we=1, rf_rd=dst+k, rf_wd=result word k. WR3 goes to IDLE with done=1 for exactly the first IDLE cycle.
- Address arithmetic is 5-bit modulo 32 (base 30 -> 30, 31, 0, 1).
  - A read of x0 returns 0 via the regfile.
  - A write to x0 is still issued (rf_we=1) and dropped by the regfile.
- Overlapping src/dst ranges are legal: all reads finish before any write.
- core_we is ignored whenever state != IDLE; core_stall is combinational from state.
- start while not IDLE is ignored and not queued.
- Latency, op_done in first EXEC cycle: start at cycle 0, RD0=1, RD1=2, EXEC=3, WR0..WR3=4..7, done and IDLE at cycle 8. Each extra EXEC wait cycle adds 1.
- Reset mid-operation: immediate IDLE, rf_we follows core_we, pending writes abandoned, no done/err pulse.

Test Plan:
- Preload x8..x11=0x00112233,0x44556677,0x8899AABB,0xCCDDEEFF; start src=8 dst=16; op_done in first EXEC cycle with result = op_state XOR all-ones -> op_state=0xCCDDEEFF_8899AABB_44556677_00112233; x16..x19=0xFFEEDDCC,0xBBAA9988,0x77665544,0x33221100; done at cycle 8; core_stall high cycles 1..7.
- Wrap: src=30, dst=31, x30=1, x31=2, op_result=0x4_3_2_1 (words) -> reads 30,31,0,1 (word2=word3=0); writes x31=1, x0 dropped, x1=3, x2=4.
- Timeout: TIMEOUT=4, op_done never asserted -> 4 EXEC cycles, err pulse, no rf_we, done stays 0; op_done on the 4th EXEC cycle -> normal writeback.
- Start pulsed during EXEC and WR1 -> ignored; exactly one done; a start in the done cycle begins a new op.
- Core passthrough: in IDLE, core_we=1, rd=5, wd=0xDEADBEEF -> x5 written; the same write during RD1 -> x5 unchanged.
- rst_n low during WR1 -> only x[dst] written, state IDLE, no done; after release, a new op runs correctly.
